fun_bist: RTL
=============

// Module: fun_bist
// PURPOSE
//  Built-in self-test sequencer for the 5-input combinational function block (a,b,c,d,e -> f).
//  Drives all 32 input vectors in order and samples the function output f for each one.
//  Compares every sample against a golden truth table, then reports pass/fail, a mismatch
//  count and the first failing vector.
//  Sits beside the function instance as its in-system stimulus/checker end.
// PARAMETERS
//  GOLDEN   32'h0000_0000  expected f per vector; GOLDEN[v] is f for {a,b,c,d,e}==v
//  SETTLE   1              extra hold cycles per vector before f is sampled (0..255)
//  ERR_W    6              width of mismatch counter; saturates at 2**ERR_W-1
// PORTS
//  clk              in   1      rising-edge clock
//  rst              in   1      asynchronous, active-high reset
//  start            in   1      run request; sampled in IDLE or DONE only
//  a,b,c,d,e        out  1 each current vector, {a,b,c,d,e}=v (a is MSB)
//  f                in   1      function output under test
//  busy             out  1      high while sweeping vectors
//  done             out  1      high in DONE until next accepted start
//  pass             out  1      valid when done: 1 = zero mismatches
//  err_cnt          out  ERR_W  mismatch count, saturating
//  first_fail_valid out  1      a mismatch has been recorded this run
//  first_fail_vec   out  5      vector index of first mismatch
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, vector=0 (a..e=0), busy=0, done=0, pass=0,
//   err_cnt=0, first_fail_valid=0, first_fail_vec=0, settle counter=0.
//  States: IDLE -> RUN on start; RUN -> DONE after vector 31 sampled; DONE -> RUN on start.
//  Accepting start (edge k, state IDLE/DONE): vector<=0, settle_cnt<=0, busy<=1, done<=0,
//   pass<=0, err_cnt<=0, first_fail_valid<=0, first_fail_vec<=0, state<=RUN.
//  RUN, each edge:
//   - settle_cnt<SETTLE: settle_cnt++ (vector held).
//   - settle_cnt==SETTLE: sample f; mismatch if f!=GOLDEN[vector].
//     On mismatch: err_cnt++ unless at max; if !first_fail_valid, latch first_fail_vec<=vector,
//     first_fail_valid<=1.
//     vector<31: vector++, settle_cnt<=0. vector==31: state<=DONE, busy<=0, done<=1,
//     pass<=(no mismatch this run incl. this sample), vector<=0.
//  Each vector is held SETTLE+1 cycles; f is sampled on the last edge of that window.
//   Run length = 32*(SETTLE+1) cycles from the accept edge to done=1.
//  start is ignored in RUN. A start held high in DONE restarts immediately (the level is
//   sampled, not an edge).
//  pass is computed from a sticky mismatch flag, not from err_cnt, so saturation cannot
//   mask failure. err_cnt holds at 2**ERR_W-1 once reached.
//  a..e are 0 in IDLE and DONE. Results stay stable in DONE until the next accepted start.
//  rst asserted mid-run aborts immediately to reset values; no partial results are kept.
//  f is sampled synchronously; the caller guarantees f settles within SETTLE+1 cycles.
// TESTING
//  1 GOLDEN=32'h6996_9669, SETTLE=0, bench f=GOLDEN[v], start pulse -> a..e count 0..31
//    one/cycle; done=1 exactly 32 cycles after accept; pass=1, err_cnt=0, first_fail_valid=0.
//  2 Same, bench inverts f only at v=5'b00110 -> pass=0, err_cnt=1, first_fail_vec=6.
//  3 ERR_W=4, bench f=~GOLDEN[v] for all v -> err_cnt=15 (saturated), pass=0,
//    first_fail_vec=0.
//  4 SETTLE=2: each vector held 3 cycles; bench glitches f wrong on first 2 cycles of each
//    vector only -> pass=1; done 96 cycles after accept.
//  5 start pulses while busy -> ignored, sweep unchanged. rst at v=10 -> all outputs to reset
//    values at once. New start -> fresh full sweep from v=0 with cleared results.
//  6 From DONE after failing run, start -> err_cnt/first_fail cleared; clean run ends pass=1.

Source files
------------

// File: rtl/fun_bist.sv
// fun_bist: BIST sequencer sweeping 32 vectors into a 5-input function and checking f against GOLDEN
//   clk, rst (async, active-high), start            : clock, reset, run request (IDLE/DONE only)
//   a,b,c,d,e                                       : current vector, a is MSB
//   f                                               : function output under test
//   busy, done, pass, err_cnt                       : run status and saturating mismatch count
//   first_fail_valid, first_fail_vec                : first mismatching vector of this run
module fun_bist #(
  parameter logic [31:0] GOLDEN = 32'h0000_0000,
  parameter int          SETTLE = 1,
  parameter int          ERR_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  input  logic             f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_fail_valid,
  output logic [4:0]       first_fail_vec
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [7:0] SETTLE_C = 8'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  logic [1:0]       state_q, state_d;
  logic [4:0]       vec_q, vec_d;
  logic [7:0]       set_q, set_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mis_q, mis_d;
  logic             ffv_q, ffv_d;
  logic [4:0]       ffvec_q, ffvec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             sample;
  logic             miss;
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    set_d   = set_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    mis_d   = mis_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    err_d   = err_q;
    sample  = (state_q == RUN) && (set_q == SETTLE_C);
    miss    = sample && (f != GOLDEN[vec_q]);
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d = RUN;
      vec_d   = 5'd0;
      set_d   = 8'd0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      mis_d   = 1'b0;
      ffv_d   = 1'b0;
      ffvec_d = 5'd0;
      err_d   = '0;
    end else if (state_q == RUN) begin
      set_d = sample ? 8'd0 : set_q + 8'd1;
      if (miss) begin
        err_d = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
        mis_d = 1'b1;
        ffv_d = 1'b1;
        ffvec_d = ffv_q ? ffvec_q : vec_q;
      end
      // vector wraps 31 -> 0, which is also the idle value of a..e
      if (sample) begin
        vec_d = vec_q + 5'd1;
        if (vec_q == 5'd31) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // sticky flag, so a saturated counter can never hide a failure
          pass_d  = !(mis_q || miss);
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 5'd0;
      set_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mis_q   <= 1'b0;
      ffv_q   <= 1'b0;
      ffvec_q <= 5'd0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      set_q   <= set_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mis_q   <= mis_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      err_q   <= err_d;
    end
  end
  assign {a, b, c, d, e}  = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_cnt          = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
endmodule
